// File: rtl/seq_mul_bcd.sv
// Sequential shift-add multiplier (signed/unsigned) with valid/ready handshakes.
// Define SEQ_MUL_BCD_CONV_EN to add the double-dabble stage that packs |product| as BCD.
module seq_mul_bcd #(
    parameter int unsigned N = 8,
    parameter int unsigned D = ((2 * N) / 3) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out,
    output logic [4*D-1:0]   bcd,
    output logic             bcd_neg
);

    localparam int unsigned CW = $clog2(2 * N + 1);
    localparam logic [N-1:0]   ZeroN  = '0;
    localparam logic [2*N-1:0] Zero2N = '0;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StBcd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [2*N-1:0]  ma_q, ma_d;
    logic [N-1:0]    mb_q, mb_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            bcd_neg_q, bcd_neg_d;

    logic [N-1:0]    a_abs, b_abs;
    logic [2*N-1:0]  acc_step;

`ifdef SEQ_MUL_BCD_CONV_EN
    logic [4*D-1:0]  bcd_q, bcd_d, bcd_adj;
`endif

    // Magnitudes fit in N unsigned bits, including -2^(N-1).
    assign a_abs    = (sgn && a_in[N-1]) ? (ZeroN - a_in) : a_in;
    assign b_abs    = (sgn && b_in[N-1]) ? (ZeroN - b_in) : b_in;
    assign acc_step = mb_q[0] ? (acc_q + ma_q) : acc_q;

`ifdef SEQ_MUL_BCD_CONV_EN
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(D); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        bcd_neg_d = bcd_neg_q;
`ifdef SEQ_MUL_BCD_CONV_EN
        bcd_d     = bcd_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ma_d      = {ZeroN, a_abs};
                    mb_d      = b_abs;
                    neg_d     = sgn & (a_in[N-1] ^ b_in[N-1]);
                    acc_d     = '0;
                    out_d     = '0;
                    bcd_neg_d = 1'b0;
                    cnt_d     = '0;
`ifdef SEQ_MUL_BCD_CONV_EN
                    bcd_d     = '0;
`endif
                    state_d   = StMul;
                end
            end
            StMul: begin
                acc_d = acc_step;
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    out_d     = neg_q ? (Zero2N - acc_step) : acc_step;
                    bcd_neg_d = neg_q & (acc_step != Zero2N);
                    cnt_d     = '0;
`ifdef SEQ_MUL_BCD_CONV_EN
                    state_d   = StBcd;
`else
                    state_d   = StDone;
`endif
                end
            end
`ifdef SEQ_MUL_BCD_CONV_EN
            StBcd: begin
                // Adjust then shift {bcd, acc} left, consuming |product| MSB first.
                bcd_d = {bcd_adj[4*D-2:0], acc_q[2*N-1]};
                acc_d = acc_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * N - 1)) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            bcd_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            bcd_neg_q <= bcd_neg_d;
        end
    end

`ifdef SEQ_MUL_BCD_CONV_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end
    assign bcd = bcd_q;
`else
    assign bcd = '0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign bcd_neg   = bcd_neg_q;

endmodule

// File: tb/tb_seq_mul_bcd.sv
// Self-checking bench for seq_mul_bcd (N=8): directed table, handshake/reset corners,
// and randomized requests checked against an arithmetic reference model.
module tb_seq_mul_bcd;

    localparam int N = 8;
    localparam int D = 6;
`ifdef SEQ_MUL_BCD_CONV_EN
    localparam int Lat = 3 * N;
`else
    localparam int Lat = N;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           sgn = 1'b0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   a_in = '0;
    logic [N-1:0]   b_in = '0;
    logic           in_ready, out_valid, bcd_neg;
    logic [2*N-1:0] out;
    logic [4*D-1:0] bcd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mul_bcd #(.N(N), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .bcd       (bcd),
        .bcd_neg   (bcd_neg)
    );

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [23:0] bd;
        logic        ng;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer product, decimal digits of its magnitude.
    function automatic void model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] p, output logic [23:0] bd,
                                  output logic ng);
        longint av, bv, pr, mag;
        av  = s ? longint'($signed(a)) : longint'(a);
        bv  = s ? longint'($signed(b)) : longint'(b);
        pr  = av * bv;
        p   = pr[15:0];
        ng  = (pr < 0);
        mag = (pr < 0) ? -pr : pr;
        bd  = '0;
        for (int i = 0; i < 6; i++) begin
            bd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
`ifndef SEQ_MUL_BCD_CONV_EN
        bd = '0;
`endif
    endfunction

    task automatic accept(input logic s, input logic [7:0] a, input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        sgn = s;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: they must only be sampled at the accept edge.
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        sgn  = 1'($urandom);
        check("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] ep, input logic [23:0] eb,
                          input logic en);
        int lat;
        logic [15:0] held;
        accept(s, a, b);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(Lat));
        check({tag, "_out"}, 64'(out), 64'(ep));
        check({tag, "_bcd"}, 64'(bcd), 64'(eb));
        check({tag, "_bcd_neg"}, 64'(bcd_neg), 64'(en));
        held = out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_after_done"}, {62'd0, in_ready, out_valid}, 64'd2);
        check({tag, "_hold_after_done"}, 64'(out), 64'(held));
    endtask

    vec_t vecs[5];

    initial begin
        vec_t v;
        logic [15:0] ep;
        logic [23:0] eb;
        logic en;
        int lat;

        vecs[0] = '{s: 1'b0, a: 8'hFF, b: 8'hFF, p: 16'hFE01, bd: 24'h065025, ng: 1'b0};
        vecs[1] = '{s: 1'b1, a: 8'h80, b: 8'h80, p: 16'h4000, bd: 24'h016384, ng: 1'b0};
        vecs[2] = '{s: 1'b1, a: 8'hFD, b: 8'h05, p: 16'hFFF1, bd: 24'h000015, ng: 1'b1};
        vecs[3] = '{s: 1'b1, a: 8'h00, b: 8'hFF, p: 16'h0000, bd: 24'h000000, ng: 1'b0};
        vecs[4] = '{s: 1'b0, a: 8'd200, b: 8'd3, p: 16'd600, bd: 24'h000600, ng: 1'b0};

        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_bcd_neg", {63'd0, bcd_neg}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
`ifdef SEQ_MUL_BCD_CONV_EN
            eb = v.bd;
`else
            eb = '0;
`endif
            run_op($sformatf("vec%0d", i), v.s, v.a, v.b, v.p, eb, v.ng);
        end

        // Back-pressure: result must stay put and new requests be refused while held.
        accept(1'b0, 8'd7, 8'd9);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'(Lat));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in = 8'd99;
            b_in = 8'd99;
            @(posedge clk);
            #1;
            check("bp_out_stable", 64'(out), 64'd63);
            check("bp_flags", {62'd0, in_ready, out_valid}, 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_released", {62'd0, in_ready, out_valid}, 64'd2);
        check("bp_out_hold", 64'(out), 64'd63);

        // Asynchronous reset in the middle of MUL.
        accept(1'b0, 8'd255, 8'd255);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_bcd", 64'(bcd), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("midreset_no_valid", {63'd0, out_valid}, 64'd0);
        end
`ifdef SEQ_MUL_BCD_CONV_EN
        eb = 24'h000120;
`else
        eb = '0;
`endif
        run_op("after_reset", 1'b0, 8'd12, 8'd10, 16'd120, eb, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v.s = 1'($urandom);
            v.a = 8'($urandom);
            v.b = 8'($urandom);
            if (i == 0) v.a = 8'h80;
            if (i == 1) v.b = 8'h00;
            model(v.s, v.a, v.b, ep, eb, en);
            run_op($sformatf("rand%0d", i), v.s, v.a, v.b, ep, eb, en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
